matrix_slot_allocator: RTL and testbench

Matrix storage manager that sits directly downstream of the matrix input stage. It serves that stage's alloc/commit handshake and owns the slot table: per-slot state, dimensions and fixed BRAM base address. It also serves free/abort requests and a dimension query port used by the compute and display modes. It does not touch BRAM data; it only hands out base addresses.

---
 rtl/matrix_slot_allocator.sv | 213 +++++++++++++++++++++
 tb/tb_matrix_slot_allocator.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/matrix_slot_allocator.sv
// Slot table for matrix storage: grants BRAM base addresses, tracks FREE/RESERVED/VALID per slot.
// Optional MATRIX_EVICT_OLDEST_EN: a full table evicts the oldest VALID slot on allocation.
module matrix_slot_allocator #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned NUM_SLOTS  = 8,
    parameter int unsigned SLOT_WORDS = 25
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    input  logic [3:0]            alloc_m,
    input  logic [3:0]            alloc_n,
    output logic                  alloc_valid,
    output logic [3:0]            alloc_slot,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  commit_req,
    input  logic [3:0]            commit_slot,
    input  logic [3:0]            commit_m,
    input  logic [3:0]            commit_n,
    input  logic [ADDR_WIDTH-1:0] commit_addr,
    input  logic                  abort_req,
    input  logic [3:0]            abort_slot,
    input  logic                  free_req,
    input  logic [3:0]            free_slot,
    input  logic [3:0]            qry_slot,
    output logic                  qry_valid,
    output logic [3:0]            qry_m,
    output logic [3:0]            qry_n,
    output logic [ADDR_WIDTH-1:0] qry_addr,
    output logic [4:0]            valid_count,
    output logic                  commit_err
);

    typedef enum logic [1:0] {
        SlotFree     = 2'd0,
        SlotReserved = 2'd1,
        SlotValid    = 2'd2
    } slot_state_e;

    localparam logic [7:0] SlotWords8 = 8'(SLOT_WORDS);

    function automatic logic [ADDR_WIDTH-1:0] base_addr(input logic [3:0] s);
        return ADDR_WIDTH'(32'(s) * SLOT_WORDS);
    endfunction

    slot_state_e state_q [NUM_SLOTS];
    slot_state_e state_d [NUM_SLOTS];
    logic [3:0]  m_q     [NUM_SLOTS];
    logic [3:0]  m_d     [NUM_SLOTS];
    logic [3:0]  n_q     [NUM_SLOTS];
    logic [3:0]  n_d     [NUM_SLOTS];

    logic [NUM_SLOTS-1:0] free_hit, abort_hit, commit_ok, commit_sel, commit_accept;
    logic [7:0]           alloc_prod;
    logic                 dims_ok, grant_found;
    logic [3:0]           grant_slot;
    logic                 commit_err_d;
    logic [4:0]           valid_count_d;
    logic                 qry_valid_d;
    logic [3:0]           qry_m_d, qry_n_d;
    logic [ADDR_WIDTH-1:0] qry_addr_d;

`ifdef MATRIX_EVICT_OLDEST_EN
    localparam logic [3:0] MaxRank = 4'(NUM_SLOTS - 1);
    logic [3:0] rank_q [NUM_SLOTS];
    logic [3:0] rank_d [NUM_SLOTS];
`endif

    assign alloc_prod = {4'd0, alloc_m} * {4'd0, alloc_n};
    assign dims_ok    = (alloc_m != 4'd0) && (alloc_n != 4'd0) && (alloc_prod <= SlotWords8);

    // Lowest-index FREE slot first; optionally fall back to the oldest VALID slot.
    always_comb begin
        logic       free_found;
        logic [3:0] free_idx;
        free_found = 1'b0;
        free_idx   = 4'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (!free_found && state_q[k] == SlotFree) begin
                free_found = 1'b1;
                free_idx   = 4'(k);
            end
        end
        grant_found = free_found;
        grant_slot  = free_idx;
`ifdef MATRIX_EVICT_OLDEST_EN
        begin
            logic       ev_found;
            logic [3:0] ev_idx;
            logic [3:0] best_rank;
            ev_found  = 1'b0;
            ev_idx    = 4'd0;
            best_rank = 4'd0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (state_q[k] == SlotValid && (!ev_found || rank_q[k] > best_rank)) begin
                    ev_found  = 1'b1;
                    ev_idx    = 4'(k);
                    best_rank = rank_q[k];
                end
            end
            if (!free_found) begin
                grant_found = ev_found;
                grant_slot  = ev_idx;
            end
        end
`endif
    end

    assign alloc_valid = alloc_req && dims_ok && grant_found;
    assign alloc_slot  = alloc_valid ? grant_slot : 4'd0;
    assign alloc_addr  = alloc_valid ? base_addr(grant_slot) : '0;

    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            free_hit[k]   = free_req && (free_slot == 4'(k)) && (state_q[k] == SlotValid);
            abort_hit[k]  = abort_req && (abort_slot == 4'(k)) && (state_q[k] == SlotReserved);
            commit_sel[k] = commit_req && (commit_slot == 4'(k));
            commit_ok[k]  = commit_sel[k] && (state_q[k] == SlotReserved) &&
                            (commit_addr == base_addr(4'(k))) &&
                            (commit_m == m_q[k]) && (commit_n == n_q[k]);
        end
        commit_accept = commit_ok & ~(free_hit | abort_hit);
        // A commit pre-empted by free/abort on the same slot is dropped silently.
        commit_err_d  = commit_req && (commit_ok == '0) &&
                        ((commit_sel & (free_hit | abort_hit)) == '0);
    end

    always_comb begin
        valid_count_d = 5'd0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            state_d[k] = state_q[k];
            m_d[k]     = m_q[k];
            n_d[k]     = n_q[k];
            if (free_hit[k] || abort_hit[k]) begin
                state_d[k] = SlotFree;
            end else if (commit_accept[k]) begin
                state_d[k] = SlotValid;
            end else if (alloc_valid && alloc_slot == 4'(k)) begin
                state_d[k] = SlotReserved;
                m_d[k]     = alloc_m;
                n_d[k]     = alloc_n;
            end
            if (state_d[k] == SlotValid) begin
                valid_count_d = valid_count_d + 5'd1;
            end
        end
    end

`ifdef MATRIX_EVICT_OLDEST_EN
    always_comb begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
            rank_d[k] = rank_q[k];
            if (commit_accept != '0) begin
                if (commit_accept[k]) begin
                    rank_d[k] = 4'd0;
                end else if (state_q[k] == SlotValid && rank_q[k] != MaxRank) begin
                    rank_d[k] = rank_q[k] + 4'd1;
                end
            end
        end
    end
`endif

    always_comb begin
        qry_valid_d = 1'b0;
        qry_m_d     = 4'd0;
        qry_n_d     = 4'd0;
        qry_addr_d  = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (qry_slot == 4'(k)) begin
                qry_valid_d = (state_q[k] == SlotValid);
                qry_m_d     = m_q[k];
                qry_n_d     = n_q[k];
                qry_addr_d  = base_addr(4'(k));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                state_q[k] <= SlotFree;
                m_q[k]     <= 4'd0;
                n_q[k]     <= 4'd0;
`ifdef MATRIX_EVICT_OLDEST_EN
                rank_q[k]  <= 4'd0;
`endif
            end
            qry_valid   <= 1'b0;
            qry_m       <= 4'd0;
            qry_n       <= 4'd0;
            qry_addr    <= '0;
            valid_count <= 5'd0;
            commit_err  <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                state_q[k] <= state_d[k];
                m_q[k]     <= m_d[k];
                n_q[k]     <= n_d[k];
`ifdef MATRIX_EVICT_OLDEST_EN
                rank_q[k]  <= rank_d[k];
`endif
            end
            qry_valid   <= qry_valid_d;
            qry_m       <= qry_m_d;
            qry_n       <= qry_n_d;
            qry_addr    <= qry_addr_d;
            valid_count <= valid_count_d;
            commit_err  <= commit_err_d;
        end
    end

endmodule

// File: tb/tb_matrix_slot_allocator.sv
// Randomized bench for matrix_slot_allocator against a table-level reference model.
// Honours MATRIX_EVICT_OLDEST_EN the same way as the design.
module tb_matrix_slot_allocator;

    localparam int AW = 9;
    localparam int NS = 8;
    localparam int SW = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_req = 1'b0;
    logic [3:0]    alloc_m = '0, alloc_n = '0;
    logic          alloc_valid;
    logic [3:0]    alloc_slot;
    logic [AW-1:0] alloc_addr;
    logic          commit_req = 1'b0;
    logic [3:0]    commit_slot = '0, commit_m = '0, commit_n = '0;
    logic [AW-1:0] commit_addr = '0;
    logic          abort_req = 1'b0;
    logic [3:0]    abort_slot = '0;
    logic          free_req = 1'b0;
    logic [3:0]    free_slot = '0;
    logic [3:0]    qry_slot = '0;
    logic          qry_valid;
    logic [3:0]    qry_m, qry_n;
    logic [AW-1:0] qry_addr;
    logic [4:0]    valid_count;
    logic          commit_err;

    always #5 clk = ~clk;

    matrix_slot_allocator #(.ADDR_WIDTH(AW), .NUM_SLOTS(NS), .SLOT_WORDS(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_m(alloc_m), .alloc_n(alloc_n),
        .alloc_valid(alloc_valid), .alloc_slot(alloc_slot), .alloc_addr(alloc_addr),
        .commit_req(commit_req), .commit_slot(commit_slot), .commit_m(commit_m),
        .commit_n(commit_n), .commit_addr(commit_addr),
        .abort_req(abort_req), .abort_slot(abort_slot),
        .free_req(free_req), .free_slot(free_slot),
        .qry_slot(qry_slot), .qry_valid(qry_valid), .qry_m(qry_m), .qry_n(qry_n),
        .qry_addr(qry_addr), .valid_count(valid_count), .commit_err(commit_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Model: 0 = free, 1 = reserved, 2 = valid; cseq records commit order for age.
    int st [16];
    int mm [16];
    int nn [16];
    int cseq [16];
    int ncommit;

    task automatic check_eq(input string tag, input logic [31:0] got, input int exp);
        n_vec++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rank_of(input int k);
        int r;
        r = ncommit - cseq[k];
        return (r > NS - 1) ? NS - 1 : r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin
            st[k] = 0; mm[k] = 0; nn[k] = 0; cseq[k] = 0;
        end
        ncommit = 0;
    endtask

    task automatic idle_inputs();
        alloc_req = 0; commit_req = 0; abort_req = 0; free_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check_eq("rst_qry_valid", qry_valid, 0);
        check_eq("rst_qry_m", qry_m, 0);
        check_eq("rst_qry_n", qry_n, 0);
        check_eq("rst_qry_addr", qry_addr, 0);
        check_eq("rst_valid_count", valid_count, 0);
        check_eq("rst_commit_err", commit_err, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input int ar, input int am, input int an,
                        input int cr, input int cs, input int cm, input int cn, input int ca,
                        input int abr, input int abs_s, input int fr, input int fs,
                        input int qs);
        int  g, best, eqv, eqm, eqn, eqa, vc;
        bit  ok, gv, fhit, ahit, clegal, cpre, eerr;
        @(negedge clk);
        alloc_req = ar[0]; alloc_m = 4'(am); alloc_n = 4'(an);
        commit_req = cr[0]; commit_slot = 4'(cs); commit_m = 4'(cm); commit_n = 4'(cn);
        commit_addr = AW'(ca);
        abort_req = abr[0]; abort_slot = 4'(abs_s);
        free_req = fr[0]; free_slot = 4'(fs);
        qry_slot = 4'(qs);
        #1;
        ok = (ar != 0) && am >= 1 && am <= 15 && an >= 1 && an <= 15 && am * an <= SW;
        g = -1;
        for (int k = 0; k < NS; k++) if (g < 0 && st[k] == 0) g = k;
`ifdef MATRIX_EVICT_OLDEST_EN
        if (g < 0) begin
            best = -1;
            for (int k = 0; k < NS; k++)
                if (st[k] == 2 && rank_of(k) > best) begin best = rank_of(k); g = k; end
        end
`endif
        gv = ok && g >= 0;
        check_eq("alloc_valid", alloc_valid, int'(gv));
        check_eq("alloc_slot", alloc_slot, gv ? g : 0);
        check_eq("alloc_addr", alloc_addr, gv ? g * SW : 0);

        eqv = 0; eqm = 0; eqn = 0; eqa = 0;
        if (qs < NS) begin
            eqv = (st[qs] == 2); eqm = mm[qs]; eqn = nn[qs]; eqa = qs * SW;
        end
        fhit   = (fr != 0) && fs < NS && st[fs] == 2;
        ahit   = (abr != 0) && abs_s < NS && st[abs_s] == 1;
        clegal = (cr != 0) && cs < NS && st[cs] == 1 && ca == cs * SW &&
                 cm == mm[cs] && cn == nn[cs];
        cpre   = (cr != 0) && ((fhit && fs == cs) || (ahit && abs_s == cs));
        eerr   = (cr != 0) && !clegal && !cpre;

        if (gv && !(fhit && fs == g)) begin
            st[g] = 1; mm[g] = am; nn[g] = an;
        end
        if (clegal && !cpre) begin
            st[cs] = 2; ncommit++; cseq[cs] = ncommit;
        end
        if (ahit) st[abs_s] = 0;
        if (fhit) st[fs] = 0;
        vc = 0;
        for (int k = 0; k < NS; k++) if (st[k] == 2) vc++;

        @(posedge clk);
        #1;
        check_eq("qry_valid", qry_valid, eqv);
        check_eq("qry_m", qry_m, eqm);
        check_eq("qry_n", qry_n, eqn);
        check_eq("qry_addr", qry_addr, eqa);
        check_eq("valid_count", valid_count, vc);
        check_eq("commit_err", commit_err, int'(eerr));
    endtask

    initial begin
        int cs, cm, cn, ca, cr, nres;
        int res_list [16];
        model_reset();
        do_reset();

        // First allocation and commit, then query it.
        step(1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Fill the table, then one allocation too many.
        for (int i = 1; i < NS; i++) begin
            step(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, i);
            step(0, 0, 0, 1, i, 3, 3, i * SW, 0, 0, 0, 0, i);
        end
        step(1, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Oversized and zero dimensions.
        step(1, 6, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
        // Bad commit address, then free slot 2 and commit to it while FREE.
        step(0, 0, 0, 1, 3, 3, 3, 74, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 2);
        step(0, 0, 0, 1, 2, 3, 3, 50, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        // Mid-sequence reset, then commit and abort colliding on slot 1.
        do_reset();
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 1, 1, 1, SW, 1, 1, 0, 0, 1);
        step(1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            nres = 0;
            for (int k = 0; k < NS; k++) if (st[k] == 1) begin res_list[nres] = k; nres++; end
            cr = ($urandom_range(0, 9) < 4) ? 1 : 0;
            if (nres > 0 && $urandom_range(0, 3) != 0) begin
                cs = res_list[$urandom_range(0, nres - 1)];
                cm = mm[cs]; cn = nn[cs]; ca = cs * SW;
                if ($urandom_range(0, 7) == 0) ca = ca + 1;
                if ($urandom_range(0, 7) == 0) cm = (cm + 1) % 16;
            end else begin
                cs = $urandom_range(0, 9); cm = $urandom_range(0, 7);
                cn = $urandom_range(0, 7); ca = cs * SW;
            end
            step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 6),
                 cr, cs, cm, cn, ca,
                 ($urandom_range(0, 5) == 0) ? 1 : 0, $urandom_range(0, 9),
                 ($urandom_range(0, 4) == 0) ? 1 : 0, $urandom_range(0, 9),
                 $urandom_range(0, 9));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
